// File: rtl/rob_retire_if.sv
// Retire-side bundle of the reorder buffer.
// Carries the dispatch group, the CDB completion broadcast, the squash
// request, the retire packets and the occupancy/stall status.
//   master : the reorder buffer (drives retire packets and status)
//   slave  : the surrounding pipeline (drives dispatch, CDB and squash)
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

interface rob_retire_if #(
  parameter int ROB_SIZE = 32,
  parameter int N_WAY    = `N_WAY,
  parameter int TAG_W    = `CDB_BITS
);
  localparam int CNT_W = $clog2(ROB_SIZE) + 1;

  typedef struct packed {
    logic             ret_valid;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] tag_old;
  } RETIRE_ROB_PACKET;

  logic [N_WAY-1:0]             dispatch_valid;
  logic [N_WAY-1:0][TAG_W-1:0]  dispatch_tag;
  logic [N_WAY-1:0][TAG_W-1:0]  dispatch_tag_old;
  logic [N_WAY-1:0]             cdb_valid;
  logic [N_WAY-1:0][TAG_W-1:0]  cdb_tag;
  logic                         squash;
  RETIRE_ROB_PACKET [N_WAY-1:0] ret_packet;
  logic [CNT_W-1:0]             free_slots;
  logic                         dispatch_stall;

  modport master (
    input  dispatch_valid, dispatch_tag, dispatch_tag_old,
    input  cdb_valid, cdb_tag, squash,
    output ret_packet, free_slots, dispatch_stall
  );

  modport slave (
    output dispatch_valid, dispatch_tag, dispatch_tag_old,
    output cdb_valid, cdb_tag, squash,
    input  ret_packet, free_slots, dispatch_stall
  );
endinterface

// File: rtl/rob_retire.sv
// Reorder buffer with in-order retirement.
// Entries are allocated at dispatch in program order, marked complete by
// CDB broadcasts and retired from the head, up to N_WAY per cycle.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   rif      : rob_retire_if.master (dispatch, cdb, squash in;
//              ret_packet, free_slots, dispatch_stall out)
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module rob_retire #(
  parameter int ROB_SIZE = 32,
  parameter int N_WAY    = `N_WAY,
  parameter int TAG_W    = `CDB_BITS
) (
  input  logic         clock,
  input  logic         reset_n,
  rob_retire_if.master rif
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(ROB_SIZE);

  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_complete;
  logic [TAG_W-1:0]    r_tag     [ROB_SIZE];
  logic [TAG_W-1:0]    r_tag_old [ROB_SIZE];
  logic [IDX_W-1:0]    r_head;
  logic [IDX_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_free_slots;
  logic                r_stall;

  logic [N_WAY-1:0]    w_ret_valid;
  logic [TAG_W-1:0]    w_ret_tag     [N_WAY];
  logic [TAG_W-1:0]    w_ret_tag_old [N_WAY];
  logic [CNT_W-1:0]    w_ret_cnt;
  logic [CNT_W-1:0]    w_disp_cnt;
  logic [CNT_W-1:0]    w_disp_acc;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [CNT_W-1:0]    w_free_nxt;
  logic                w_disp_ok;
  logic                w_chain;
  logic [IDX_W-1:0]    w_ridx;
  logic [IDX_W-1:0]    w_cidx;
  logic [IDX_W-1:0]    w_widx;
  logic [ROB_SIZE-1:0] w_cdb_hit;
  logic [ROB_SIZE-1:0] w_valid_nxt;
  logic [ROB_SIZE-1:0] w_complete_nxt;

  // Retire window: a lane fires only if every older lane also fires, so the
  // chain breaks at the first invalid or incomplete entry. Squash kills it.
  always_comb begin
    w_ret_valid = '0;
    w_ret_cnt   = '0;
    w_chain     = ~rif.squash;
    w_ridx      = '0;
    for (int k = 0; k < N_WAY; k++) begin
      w_ridx           = r_head + IDX_W'(k);
      w_chain          = w_chain & r_valid[w_ridx] & r_complete[w_ridx];
      w_ret_valid[k]   = w_chain;
      w_ret_tag[k]     = w_chain ? r_tag[w_ridx]     : '0;
      w_ret_tag_old[k] = w_chain ? r_tag_old[w_ridx] : '0;
      w_ret_cnt        = w_ret_cnt + CNT_W'(w_chain);
    end
  end

  // Tag match against every live entry; invalid entries hold stale tags.
  always_comb begin
    w_cdb_hit = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      for (int l = 0; l < N_WAY; l++) begin
        if (rif.cdb_valid[l] && (rif.cdb_tag[l] == r_tag[i])) begin
          w_cdb_hit[i] = 1'b1;
        end
      end
    end
    w_cdb_hit = w_cdb_hit & r_valid;
  end

  // Dispatch is all-or-nothing against the free count seen at cycle start;
  // slots released by this cycle's retire are not yet available.
  always_comb begin
    w_disp_cnt = '0;
    for (int l = 0; l < N_WAY; l++) begin
      w_disp_cnt = w_disp_cnt + CNT_W'(rif.dispatch_valid[l]);
    end
    w_disp_ok   = ~rif.squash && (w_disp_cnt <= r_free_slots);
    w_disp_acc  = w_disp_ok ? w_disp_cnt : '0;
    w_count_nxt = r_count + w_disp_acc - w_ret_cnt;
    w_free_nxt  = SIZE_C - w_count_nxt;
  end

  // Retired and dispatched slots never overlap: dispatch only targets
  // free slots and retire only clears occupied ones.
  always_comb begin
    w_valid_nxt    = r_valid;
    w_complete_nxt = r_complete | w_cdb_hit;
    w_cidx         = '0;
    w_widx         = '0;
    for (int k = 0; k < N_WAY; k++) begin
      w_cidx = r_head + IDX_W'(k);
      if (w_ret_valid[k]) begin
        w_valid_nxt[w_cidx] = 1'b0;
      end
    end
    for (int k = 0; k < N_WAY; k++) begin
      w_widx = r_tail + IDX_W'(k);
      if (w_disp_ok && rif.dispatch_valid[k]) begin
        w_valid_nxt[w_widx]    = 1'b1;
        w_complete_nxt[w_widx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= '0;
      r_complete   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_free_slots <= SIZE_C;
      r_stall      <= 1'b0;
    end else if (rif.squash) begin
      r_valid      <= '0;
      r_complete   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_free_slots <= SIZE_C;
      r_stall      <= 1'b0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_complete   <= w_complete_nxt;
      r_head       <= r_head + w_ret_cnt[IDX_W-1:0];
      r_tail       <= r_tail + w_disp_acc[IDX_W-1:0];
      r_count      <= w_count_nxt;
      r_free_slots <= w_free_nxt;
      r_stall      <= (w_free_nxt < CNT_W'(N_WAY));
    end
  end

  // Tag storage carries no reset; it is only observed through valid entries.
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_WAY; k++) begin
      if (w_disp_ok && rif.dispatch_valid[k]) begin
        r_tag[r_tail + IDX_W'(k)]     <= rif.dispatch_tag[k];
        r_tag_old[r_tail + IDX_W'(k)] <= rif.dispatch_tag_old[k];
      end
    end
  end

  assign rif.free_slots     = r_free_slots;
  assign rif.dispatch_stall = r_stall;

  for (genvar k = 0; k < N_WAY; k++) begin : g_ret
    assign rif.ret_packet[k] = {w_ret_valid[k], w_ret_tag[k], w_ret_tag_old[k]};
  end

endmodule
